// File: rtl/mountaincar_episode_ctrl_if.sv
// Agent and compute-core channels of the MountainCar episode controller.
// Latency: none (wires only).
// Backpressure: act channel valid/ready, obs channel valid/ready, core channel enable/valid.
// Ports: agent action (i_act_valid/o_act_ready/i_act), observation (o_obs_*/i_obs_ready),
//        core drive (o_cmp_ena/o_cmp_pos/o_cmp_vel/o_cmp_act), core return (i_cmp_*).
// Modports: slave = the controller, master = the agent plus compute core facing it.
interface mountaincar_episode_ctrl_if #(
    parameter int POS_WL = 32,
    parameter int VEL_WL = 32,
    parameter int ACT_WL = 2,
    parameter int RWD_WL = 1
);
    logic              i_act_valid;
    logic              o_act_ready;
    logic [ACT_WL-1:0] i_act;

    logic              o_obs_valid;
    logic              i_obs_ready;
    logic [POS_WL-1:0] o_obs_pos;
    logic [VEL_WL-1:0] o_obs_vel;
    logic [RWD_WL-1:0] o_obs_rwd;
    logic              o_obs_done;
    logic              o_obs_trunc;

    logic              o_cmp_ena;
    logic [POS_WL-1:0] o_cmp_pos;
    logic [VEL_WL-1:0] o_cmp_vel;
    logic [ACT_WL-1:0] o_cmp_act;
    logic [POS_WL-1:0] i_cmp_pos;
    logic [VEL_WL-1:0] i_cmp_vel;
    logic [RWD_WL-1:0] i_cmp_rwd;
    logic              i_cmp_done;
    logic              i_cmp_valid;

    modport slave (
        input  i_act_valid, i_act, i_obs_ready,
        input  i_cmp_pos, i_cmp_vel, i_cmp_rwd, i_cmp_done, i_cmp_valid,
        output o_act_ready, o_obs_valid, o_obs_pos, o_obs_vel, o_obs_rwd, o_obs_done, o_obs_trunc,
        output o_cmp_ena, o_cmp_pos, o_cmp_vel, o_cmp_act
    );

    modport master (
        output i_act_valid, i_act, i_obs_ready,
        output i_cmp_pos, i_cmp_vel, i_cmp_rwd, i_cmp_done, i_cmp_valid,
        input  o_act_ready, o_obs_valid, o_obs_pos, o_obs_vel, o_obs_rwd, o_obs_done, o_obs_trunc,
        input  o_cmp_ena, o_cmp_pos, o_cmp_vel, o_cmp_act
    );
endinterface

// File: rtl/mountaincar_episode_ctrl.sv
// Episode sequencer: holds pos/vel, takes one action per step, runs the core, presents the observation.
// Latency: action accept -> o_obs_valid = 2 + core latency; obs accept -> o_act_ready = 1 cycle.
// Backpressure: observation held stable until i_obs_ready; no action accepted while a step is in flight.
// Ports: i_clk/i_rst (sync, active-high), i_start/i_init_pos, o_step_cnt, o_busy, bus (agent + core channels).
// Optional: MC_CMP_TIMEOUT_EN adds TMO_CYC and sticky o_tmo_err; the core is abandoned after TMO_CYC cycles.
module mountaincar_episode_ctrl #(
    parameter int POS_WL   = 32,
    parameter int VEL_WL   = 32,
    parameter int ACT_WL   = 2,
    parameter int RWD_WL   = 1,
    parameter int MAX_STEP = 200,
    parameter int CNT_WL   = 8
`ifdef MC_CMP_TIMEOUT_EN
    ,
    parameter int TMO_CYC  = 1024
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [POS_WL-1:0]        i_init_pos,
    output logic [CNT_WL-1:0]        o_step_cnt,
    output logic                     o_busy,
`ifdef MC_CMP_TIMEOUT_EN
    output logic                     o_tmo_err,
`endif
    mountaincar_episode_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WAIT_ACT, LAUNCH, WAIT_CMP, PRESENT} state_t;

    state_t            state_q, state_d;
    logic [POS_WL-1:0] pos_q, pos_d;
    logic [VEL_WL-1:0] vel_q, vel_d;
    logic [ACT_WL-1:0] act_q, act_d;
    logic [CNT_WL-1:0] step_cnt_q, step_cnt_d;
    logic              busy_q, busy_d;
    logic              act_ready_q, act_ready_d;
    logic              obs_valid_q, obs_valid_d;
    logic [POS_WL-1:0] obs_pos_q, obs_pos_d;
    logic [VEL_WL-1:0] obs_vel_q, obs_vel_d;
    logic [RWD_WL-1:0] obs_rwd_q, obs_rwd_d;
    logic              obs_done_q, obs_done_d;
    logic              obs_trunc_q, obs_trunc_d;
    logic              cmp_ena_q, cmp_ena_d;
    logic [POS_WL-1:0] cmp_pos_q, cmp_pos_d;
    logic [VEL_WL-1:0] cmp_vel_q, cmp_vel_d;
    logic [ACT_WL-1:0] cmp_act_q, cmp_act_d;
`ifdef MC_CMP_TIMEOUT_EN
    localparam int TMO_WL = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TMO_WL-1:0] tmo_cnt_q, tmo_cnt_d;
    logic              tmo_err_q, tmo_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        vel_d       = vel_q;
        act_d       = act_q;
        step_cnt_d  = step_cnt_q;
        busy_d      = busy_q;
        act_ready_d = act_ready_q;
        obs_valid_d = obs_valid_q;
        obs_pos_d   = obs_pos_q;
        obs_vel_d   = obs_vel_q;
        obs_rwd_d   = obs_rwd_q;
        obs_done_d  = obs_done_q;
        obs_trunc_d = obs_trunc_q;
        cmp_ena_d   = cmp_ena_q;
        cmp_pos_d   = cmp_pos_q;
        cmp_vel_d   = cmp_vel_q;
        cmp_act_d   = cmp_act_q;
`ifdef MC_CMP_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = WAIT_ACT;
                    pos_d       = i_init_pos;
                    vel_d       = '0;
                    step_cnt_d  = '0;
                    busy_d      = 1'b1;
                    act_ready_d = 1'b1;
`ifdef MC_CMP_TIMEOUT_EN
                    tmo_err_d   = 1'b0;
`endif
                end
            end
            WAIT_ACT: begin
                if (bus.i_act_valid && act_ready_q) begin
                    act_d       = bus.i_act;
                    act_ready_d = 1'b0;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                // Core inputs are frozen here and stay untouched for the whole WAIT_CMP stay.
                cmp_pos_d = pos_q;
                cmp_vel_d = vel_q;
                cmp_act_d = act_q;
                cmp_ena_d = 1'b1;
                state_d   = WAIT_CMP;
`ifdef MC_CMP_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT_CMP: begin
                if (bus.i_cmp_valid) begin
                    pos_d       = bus.i_cmp_pos;
                    vel_d       = bus.i_cmp_vel;
                    obs_pos_d   = bus.i_cmp_pos;
                    obs_vel_d   = bus.i_cmp_vel;
                    obs_rwd_d   = bus.i_cmp_rwd;
                    obs_done_d  = bus.i_cmp_done;
                    // Saturating: the counter parks at the limit instead of wrapping.
                    step_cnt_d  = (step_cnt_q == CNT_WL'(MAX_STEP)) ? step_cnt_q
                                                                    : step_cnt_q + CNT_WL'(1);
                    // Goal takes precedence: a step that both reaches the goal and the limit is done, not truncated.
                    obs_trunc_d = (step_cnt_d == CNT_WL'(MAX_STEP)) && !bus.i_cmp_done;
                    obs_valid_d = 1'b1;
                    cmp_ena_d   = 1'b0;
                    state_d     = PRESENT;
                end
`ifdef MC_CMP_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_WL'(TMO_CYC - 1)) begin
                    cmp_ena_d = 1'b0;
                    tmo_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_WL'(1);
                end
`endif
            end
            PRESENT: begin
                if (bus.i_obs_ready) begin
                    obs_valid_d = 1'b0;
                    if (obs_done_q || obs_trunc_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        act_ready_d = 1'b1;
                        state_d     = WAIT_ACT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            vel_q       <= '0;
            act_q       <= '0;
            step_cnt_q  <= '0;
            busy_q      <= 1'b0;
            act_ready_q <= 1'b0;
            obs_valid_q <= 1'b0;
            obs_pos_q   <= '0;
            obs_vel_q   <= '0;
            obs_rwd_q   <= '0;
            obs_done_q  <= 1'b0;
            obs_trunc_q <= 1'b0;
            cmp_ena_q   <= 1'b0;
            cmp_pos_q   <= '0;
            cmp_vel_q   <= '0;
            cmp_act_q   <= '0;
`ifdef MC_CMP_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            act_q       <= act_d;
            step_cnt_q  <= step_cnt_d;
            busy_q      <= busy_d;
            act_ready_q <= act_ready_d;
            obs_valid_q <= obs_valid_d;
            obs_pos_q   <= obs_pos_d;
            obs_vel_q   <= obs_vel_d;
            obs_rwd_q   <= obs_rwd_d;
            obs_done_q  <= obs_done_d;
            obs_trunc_q <= obs_trunc_d;
            cmp_ena_q   <= cmp_ena_d;
            cmp_pos_q   <= cmp_pos_d;
            cmp_vel_q   <= cmp_vel_d;
            cmp_act_q   <= cmp_act_d;
`ifdef MC_CMP_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    assign bus.o_act_ready = act_ready_q;
    assign bus.o_obs_valid = obs_valid_q;
    assign bus.o_obs_pos   = obs_pos_q;
    assign bus.o_obs_vel   = obs_vel_q;
    assign bus.o_obs_rwd   = obs_rwd_q;
    assign bus.o_obs_done  = obs_done_q;
    assign bus.o_obs_trunc = obs_trunc_q;
    assign bus.o_cmp_ena   = cmp_ena_q;
    assign bus.o_cmp_pos   = cmp_pos_q;
    assign bus.o_cmp_vel   = cmp_vel_q;
    assign bus.o_cmp_act   = cmp_act_q;
    assign o_step_cnt      = step_cnt_q;
    assign o_busy          = busy_q;
`ifdef MC_CMP_TIMEOUT_EN
    assign o_tmo_err       = tmo_err_q;
`endif

endmodule

// File: tb/tb_mountaincar_episode_ctrl.sv
// Bench for mountaincar_episode_ctrl: dut_a uses MAX_STEP=200, dut_b uses MAX_STEP=4.
// A shared set of stimulus signals is steered to one DUT by 'sel'; the other sees idle inputs.
// Expected observations are queued when the core result is driven and popped when o_obs_valid rises.
module tb_mountaincar_episode_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sel;
    logic [31:0] init_pos;
    logic        act_valid, obs_ready;
    logic [1:0]  act;
    logic [31:0] cmp_pos_in, cmp_vel_in;
    logic        cmp_rwd_in, cmp_done_in, cmp_valid_in;

    logic [7:0]  cnt_a, cnt_b;
    logic        busy_a, busy_b;
    logic        tmo_err_a, tmo_err_b;

    mountaincar_episode_ctrl_if bus_a ();
    mountaincar_episode_ctrl_if bus_b ();

    assign bus_a.i_act_valid = act_valid & ~sel;
    assign bus_b.i_act_valid = act_valid & sel;
    assign bus_a.i_obs_ready = obs_ready & ~sel;
    assign bus_b.i_obs_ready = obs_ready & sel;
    assign bus_a.i_cmp_valid = cmp_valid_in & ~sel;
    assign bus_b.i_cmp_valid = cmp_valid_in & sel;
    assign bus_a.i_act = act;       assign bus_b.i_act = act;
    assign bus_a.i_cmp_pos = cmp_pos_in;   assign bus_b.i_cmp_pos = cmp_pos_in;
    assign bus_a.i_cmp_vel = cmp_vel_in;   assign bus_b.i_cmp_vel = cmp_vel_in;
    assign bus_a.i_cmp_rwd = cmp_rwd_in;   assign bus_b.i_cmp_rwd = cmp_rwd_in;
    assign bus_a.i_cmp_done = cmp_done_in; assign bus_b.i_cmp_done = cmp_done_in;

    mountaincar_episode_ctrl #(
        .MAX_STEP(200)
`ifdef MC_CMP_TIMEOUT_EN
        , .TMO_CYC(16)
`endif
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .i_init_pos(init_pos),
        .o_step_cnt(cnt_a), .o_busy(busy_a),
`ifdef MC_CMP_TIMEOUT_EN
        .o_tmo_err(tmo_err_a),
`endif
        .bus(bus_a)
    );

    mountaincar_episode_ctrl #(
        .MAX_STEP(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel), .i_init_pos(init_pos),
        .o_step_cnt(cnt_b), .o_busy(busy_b),
`ifdef MC_CMP_TIMEOUT_EN
        .o_tmo_err(tmo_err_b),
`endif
        .bus(bus_b)
    );

`ifndef MC_CMP_TIMEOUT_EN
    assign tmo_err_a = 1'b0;
    assign tmo_err_b = 1'b0;
`endif

    // Outputs of the selected DUT.
    wire        act_ready = sel ? bus_b.o_act_ready : bus_a.o_act_ready;
    wire        obs_valid = sel ? bus_b.o_obs_valid : bus_a.o_obs_valid;
    wire [31:0] obs_pos   = sel ? bus_b.o_obs_pos   : bus_a.o_obs_pos;
    wire [31:0] obs_vel   = sel ? bus_b.o_obs_vel   : bus_a.o_obs_vel;
    wire        obs_rwd   = sel ? bus_b.o_obs_rwd   : bus_a.o_obs_rwd;
    wire        obs_done  = sel ? bus_b.o_obs_done  : bus_a.o_obs_done;
    wire        obs_trunc = sel ? bus_b.o_obs_trunc : bus_a.o_obs_trunc;
    wire        cmp_ena   = sel ? bus_b.o_cmp_ena   : bus_a.o_cmp_ena;
    wire [31:0] cmp_pos   = sel ? bus_b.o_cmp_pos   : bus_a.o_cmp_pos;
    wire [31:0] cmp_vel   = sel ? bus_b.o_cmp_vel   : bus_a.o_cmp_vel;
    wire [1:0]  cmp_act   = sel ? bus_b.o_cmp_act   : bus_a.o_cmp_act;
    wire [7:0]  step_cnt  = sel ? cnt_b : cnt_a;
    wire        busy      = sel ? busy_b : busy_a;

    typedef struct {
        logic [31:0] pos;
        logic [31:0] vel;
        logic        rwd;
        logic        done;
        logic        trunc;
        int          cnt;
    } obs_t;

    obs_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pos, exp_vel;
    int          cnt_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; act_valid = 1'b1; act = 2'd2;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            checks++;
            if ({act_ready, obs_valid, busy, cmp_ena, obs_done, obs_trunc, tmo_err_a} !== 7'b0 ||
                cmp_pos !== 32'h0 || obs_pos !== 32'h0 || step_cnt !== 8'h0)
                begin failures++; $display("FAIL reset_state dut%0d: rdy=%b vld=%b busy=%b ena=%b cmp_pos=%h obs_pos=%h cnt=%0d required all 0",
                    d, act_ready, obs_valid, busy, cmp_ena, cmp_pos, obs_pos, step_cnt); end
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (act_ready !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL reset_act_ignored: act_ready=%b busy=%b required 0 0", act_ready, busy); end
        act_valid = 1'b0;
    endtask

    task automatic start_episode(input logic [31:0] pos);
        init_pos = pos; start = 1'b1;
        tick();
        start = 1'b0;
        exp_pos = pos; exp_vel = 32'h0; cnt_m = 0;
        checks++;
        if (busy !== 1'b1 || act_ready !== 1'b1 || step_cnt !== 8'd0 || tmo_err_a !== 1'b0)
            begin failures++; $display("FAIL start: busy=%b act_ready=%b cnt=%0d tmo=%b required 1 1 0 0", busy, act_ready, step_cnt, tmo_err_a); end
    endtask

    // One full step: action handshake, core model with cl extra cycles, observation with stall cycles.
    task automatic do_step(input logic [1:0] a, input logic [31:0] npos, input logic [31:0] nvel,
                           input logic rwd, input logic done, input int cl, input int stall, input int max_step);
        obs_t got;
        int   lat;
        logic end_ep;
        act = a; act_valid = 1'b1;
        lat = 0;
        while (act_ready !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++;
        if (act_ready !== 1'b1) begin failures++; $display("FAIL act_ready_wait: act_ready=%b required 1", act_ready); end
        tick();
        act_valid = 1'b0; act = 2'd3;
        lat = 0;
        do begin tick(); lat++; end while (cmp_ena !== 1'b1 && lat < 20);
        checks++;
        if (lat != 1 || cmp_pos !== exp_pos || cmp_vel !== exp_vel || cmp_act !== a || act_ready !== 1'b0)
            begin failures++; $display("FAIL launch: lat=%0d pos=%h vel=%h act=%0d rdy=%b required 1 %h %h %0d 0",
                lat, cmp_pos, cmp_vel, cmp_act, act_ready, exp_pos, exp_vel, a); end
        for (int i = 0; i < cl; i++) begin
            tick(); lat++;
            checks++;
            if (cmp_ena !== 1'b1 || cmp_pos !== exp_pos || cmp_vel !== exp_vel || cmp_act !== a || obs_valid !== 1'b0)
                begin failures++; $display("FAIL core_hold: ena=%b pos=%h vel=%h required 1 %h %h", cmp_ena, cmp_pos, cmp_vel, exp_pos, exp_vel); end
        end
        cmp_pos_in = npos; cmp_vel_in = nvel; cmp_rwd_in = rwd; cmp_done_in = done; cmp_valid_in = 1'b1;
        if (cnt_m < max_step) cnt_m++;
        sb.push_back('{pos: npos, vel: nvel, rwd: rwd, done: done, trunc: (cnt_m == max_step) && !done, cnt: cnt_m});
        tick(); lat++;
        cmp_valid_in = 1'b0; cmp_pos_in = ~npos; cmp_vel_in = ~nvel; cmp_done_in = ~done;
        while (obs_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
        checks++;
        if (obs_valid !== 1'b1 || lat != 2 + cl || cmp_ena !== 1'b0 || act_ready !== 1'b0)
            begin failures++; $display("FAIL obs_latency: vld=%b lat=%0d ena=%b rdy=%b required 1 %0d 0 0", obs_valid, lat, cmp_ena, act_ready, 2 + cl); end
        if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL scoreboard_empty: size=0 required 1");
            return;
        end
        got = sb.pop_front();
        for (int i = 0; i <= stall; i++) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_pos !== got.pos || obs_vel !== got.vel || obs_rwd !== got.rwd ||
                obs_done !== got.done || obs_trunc !== got.trunc || step_cnt !== 8'(got.cnt) || act_ready !== 1'b0)
                begin failures++; $display("FAIL obs_fields cyc%0d: vld=%b pos=%h vel=%h rwd=%b done=%b trunc=%b cnt=%0d required 1 %h %h %b %b %b %0d",
                    i, obs_valid, obs_pos, obs_vel, obs_rwd, obs_done, obs_trunc, step_cnt, got.pos, got.vel, got.rwd, got.done, got.trunc, got.cnt); end
            if (i < stall) tick();
        end
        obs_ready = 1'b1;
        tick();
        obs_ready = 1'b0;
        end_ep = got.done | got.trunc;
        checks++;
        if (obs_valid !== 1'b0 || act_ready !== !end_ep || busy !== !end_ep || cmp_ena !== 1'b0)
            begin failures++; $display("FAIL obs_accept: vld=%b rdy=%b busy=%b ena=%b required 0 %b %b 0", obs_valid, act_ready, busy, cmp_ena, !end_ep, !end_ep); end
        exp_pos = npos; exp_vel = nvel;
    endtask

    task automatic test_single_step();
        sel = 1'b0;
        start_episode(32'hbef2ae91);
        do_step(2'd2, 32'hbef25c16, 32'h3a24f712, 1'b1, 1'b0, 3, 0, 200);
    endtask

    task automatic test_chained_backpressure();
        sel = 1'b0;
        for (int s = 0; s < 10; s++)
            do_step(2'($urandom_range(2)), $urandom, $urandom, 1'($urandom), 1'b0, $urandom_range(4), 5, 200);
    endtask

    task automatic test_goal();
        sel = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || step_cnt !== 8'd0)
            begin failures++; $display("FAIL goal_pre_reset: busy=%b cnt=%0d required 0 0", busy, step_cnt); end
        start_episode(32'hbf000000);
        do_step(2'd0, 32'hbf010000, 32'hb9800000, 1'b1, 1'b0, 1, 1, 200);
        do_step(2'd1, 32'hbf020000, 32'hb9900000, 1'b1, 1'b0, 0, 0, 200);
        do_step(2'd2, 32'h3f000000, 32'h3a000000, 1'b0, 1'b1, 2, 2, 200);
        tick();
        checks++;
        if (busy !== 1'b0 || act_ready !== 1'b0 || step_cnt !== 8'd3)
            begin failures++; $display("FAIL goal_idle: busy=%b rdy=%b cnt=%0d required 0 0 3", busy, act_ready, step_cnt); end
    endtask

    task automatic test_truncation();
        sel = 1'b1;
        start_episode(32'hbe800000);
        do_step(2'd2, 32'hbe700000, 32'h39000000, 1'b1, 1'b0, 0, 1, 4);
        init_pos = 32'h12345678; start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || act_ready !== 1'b1 || step_cnt !== 8'd1)
            begin failures++; $display("FAIL start_ignored: busy=%b rdy=%b cnt=%0d required 1 1 1", busy, act_ready, step_cnt); end
        for (int s = 0; s < 3; s++)
            do_step(2'd1, 32'hbe600000 + 32'(s), 32'h38000000 + 32'(s), 1'b1, 1'b0, s, 1, 4);
        checks++;
        if (busy !== 1'b0 || step_cnt !== 8'd4)
            begin failures++; $display("FAIL trunc_idle: busy=%b cnt=%0d required 0 4", busy, step_cnt); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_step();
        int n;
        sel = 1'b0;
        start_episode(32'hbf200000);
        act = 2'd0; act_valid = 1'b1; tick(); act_valid = 1'b0;
        n = 0;
        while (cmp_ena !== 1'b1 && n < 10) begin tick(); n++; end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (cmp_ena !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL rst_mid: ena=%b busy=%b required 0 0", cmp_ena, busy); end
        cmp_pos_in = 32'h3f800000; cmp_vel_in = 32'h3a800000; cmp_done_in = 1'b1; cmp_valid_in = 1'b1;
        tick(); tick();
        cmp_valid_in = 1'b0;
        tick();
        checks++;
        if (obs_valid !== 1'b0 || busy !== 1'b0 || step_cnt !== 8'd0 || act_ready !== 1'b0 || obs_pos !== 32'h0)
            begin failures++; $display("FAIL late_valid: vld=%b busy=%b cnt=%0d rdy=%b pos=%h required 0 0 0 0 0", obs_valid, busy, step_cnt, act_ready, obs_pos); end
    endtask

`ifdef MC_CMP_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        sel = 1'b0;
        start_episode(32'hbf300000);
        act = 2'd1; act_valid = 1'b1; tick(); act_valid = 1'b0;
        n = 0;
        while (cmp_ena !== 1'b1 && n < 10) begin tick(); n++; end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++;
            if (tmo_err_a !== 1'b0 || cmp_ena !== 1'b1)
                begin failures++; $display("FAIL tmo_early cyc%0d: tmo=%b ena=%b required 0 1", i, tmo_err_a, cmp_ena); end
        end
        tick();
        checks++;
        if (tmo_err_a !== 1'b1 || cmp_ena !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL tmo_fire: tmo=%b ena=%b busy=%b required 1 0 0", tmo_err_a, cmp_ena, busy); end
        tick();
        checks++;
        if (tmo_err_a !== 1'b1)
            begin failures++; $display("FAIL tmo_sticky: tmo=%b required 1", tmo_err_a); end
        start_episode(32'hbf310000);
        rst = 1'b1; tick(); rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; init_pos = '0;
        act_valid = 1'b0; act = '0; obs_ready = 1'b0;
        cmp_pos_in = '0; cmp_vel_in = '0; cmp_rwd_in = 1'b0; cmp_done_in = 1'b0; cmp_valid_in = 1'b0;
        exp_pos = '0; exp_vel = '0; cnt_m = 0;
        test_reset();
        test_single_step();
        test_chained_backpressure();
        test_goal();
        test_truncation();
        test_reset_mid_step();
`ifdef MC_CMP_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
